// File: rtl/pc_stack.sv
// pc_stack: Hack CPU program counter with an integrated return-address stack.
// Latency: every command takes effect at the rising edge that samples it; outputs are registered state.
// Option: define PC_STACK_FAULT_EN to trap overflow/underflow into a sticky err flag; otherwise the stack is circular.
module pc_stack #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  // Return-address storage; contents are don't-care after reset, so no reset on the array.
  logic [WIDTH-1:0] stack [DEPTH];

  // sp is the write index (next free slot), wrapping mod DEPTH; depth_q counts valid entries.
  logic [AW-1:0]    sp, sp_nxt, sp_dec;
  logic [DW-1:0]    depth_q, depth_nxt;
  logic [WIDTH-1:0] out_q, out_nxt, ret_addr, top;
  logic             err_q, err_nxt;
  logic             push_en;
  logic             full_w, empty_w;

  assign ret_addr = out_q + WIDTH'(1);
  assign sp_dec   = sp - AW'(1);
  assign top      = stack[sp_dec];
  assign full_w   = (depth_q == DW'(DEPTH));
  assign empty_w  = (depth_q == '0);

  // Next-state decode; priority is call > ret > load > inc > hold (reset is applied in the register).
  always_comb begin
    out_nxt   = out_q;
    depth_nxt = depth_q;
    sp_nxt    = sp;
    err_nxt   = err_q;
    push_en   = 1'b0;
    if (call) begin
      out_nxt = in;
`ifdef PC_STACK_FAULT_EN
      if (full_w) begin
        // Overflow: jump still happens, but the return address is dropped.
        err_nxt = 1'b1;
      end else begin
        push_en   = 1'b1;
        sp_nxt    = sp + AW'(1);
        depth_nxt = depth_q + DW'(1);
      end
`else
      // Circular stack: overflow overwrites the oldest entry, depth saturates.
      push_en = 1'b1;
      sp_nxt  = sp + AW'(1);
      if (!full_w) depth_nxt = depth_q + DW'(1);
`endif
    end else if (ret) begin
`ifdef PC_STACK_FAULT_EN
      if (empty_w) begin
        // Underflow: PC holds.
        err_nxt = 1'b1;
      end else begin
        out_nxt   = top;
        sp_nxt    = sp_dec;
        depth_nxt = depth_q - DW'(1);
      end
`else
      // Underflow jumps to whatever stale entry sits at the wrapped index.
      out_nxt = top;
      sp_nxt  = sp_dec;
      if (!empty_w) depth_nxt = depth_q - DW'(1);
`endif
    end else if (load) begin
      out_nxt = in;
    end else if (inc) begin
      out_nxt = ret_addr;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= RESET_VEC;
      depth_q <= '0;
      sp      <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_nxt;
      depth_q <= depth_nxt;
      sp      <= sp_nxt;
      err_q   <= err_nxt;
    end
  end

  // Stack write; a call sampled together with reset must not push.
  always_ff @(posedge clk) begin
    if (push_en && !reset) stack[sp] <= ret_addr;
  end

  assign out   = out_q;
  assign depth = depth_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed vectors with a scoreboard queue for pc_stack (WIDTH=16, DEPTH=4).
// Stimulus is driven on the falling edge; the monitor checks state 1 time unit after each rising edge.
// Expected values depend on whether PC_STACK_FAULT_EN is defined.
module tb_pc_stack;

`ifdef PC_STACK_FAULT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, load, inc, call, ret;
  logic [15:0] in;
  logic [15:0] out;
  logic [2:0]  depth;
  logic        empty, full, err;

  pc_stack #(.WIDTH(16), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
    .call(call), .ret(ret), .out(out), .depth(depth),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic [2:0]  depth;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation compares the registered state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.name, ".out"},   32'(out),   32'(e.out));
        check({e.name, ".depth"}, 32'(depth), 32'(e.depth));
        check({e.name, ".empty"}, 32'(empty), 32'(e.depth == 3'd0));
        check({e.name, ".full"},  32'(full),  32'(e.depth == 3'd4));
        check({e.name, ".err"},   32'(err),   32'(e.err));
      end
    end
  end

  task automatic step(input string name, input logic rs, input logic c, input logic r,
                      input logic l, input logic n, input logic [15:0] din,
                      input logic [15:0] eo, input logic [2:0] ed, input logic ee);
    exp_t e;
    @(negedge clk);
    reset = rs; call = c; ret = r; load = l; inc = n; in = din;
    e.name = name; e.out = eo; e.depth = ed; e.err = ee;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; in = '0;
    //    name         rs c r l n  in        out       d  err
    step("reset",      1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("load",       0, 0, 0, 1, 0, 16'h1234, 16'h1234, 0, 0);
    step("inc",        0, 0, 0, 0, 1, 16'h0000, 16'h1235, 0, 0);
    step("idle",       0, 0, 0, 0, 0, 16'h0000, 16'h1235, 0, 0);
    step("load10",     0, 0, 0, 1, 0, 16'h0010, 16'h0010, 0, 0);
    step("call100",    0, 1, 0, 0, 0, 16'h0100, 16'h0100, 1, 0);
    step("call200",    0, 1, 0, 0, 0, 16'h0200, 16'h0200, 2, 0);
    step("ret1",       0, 0, 1, 0, 0, 16'h0000, 16'h0101, 1, 0);
    step("ret2",       0, 0, 1, 0, 0, 16'h0000, 16'h0011, 0, 0);
    step("loadffff",   0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    step("incwrap",    0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    step("loadffff2",  0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    step("callwrap",   0, 1, 0, 0, 0, 16'h0050, 16'h0050, 1, 0);
    step("retwrap",    0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("load20",     0, 0, 0, 1, 0, 16'h0020, 16'h0020, 0, 0);
    step("prio",       0, 1, 1, 1, 1, 16'h0300, 16'h0300, 1, 0);
    step("prioret",    0, 0, 1, 0, 0, 16'h0000, 16'h0021, 0, 0);
    // Overflow / underflow on a 4-deep stack.
    step("reset2",     1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("load1000",   0, 0, 0, 1, 0, 16'h1000, 16'h1000, 0, 0);
    step("ocall1",     0, 1, 0, 0, 0, 16'h2000, 16'h2000, 1, 0);
    step("ocall2",     0, 1, 0, 0, 0, 16'h3000, 16'h3000, 2, 0);
    step("ocall3",     0, 1, 0, 0, 0, 16'h4000, 16'h4000, 3, 0);
    step("ocall4",     0, 1, 0, 0, 0, 16'h5000, 16'h5000, 4, 0);
    step("ocall5",     0, 1, 0, 0, 0, 16'h6000, 16'h6000, 4, FAULT);
    step("oret1",      0, 0, 1, 0, 0, 16'h0000, FAULT ? 16'h4001 : 16'h5001, 3, FAULT);
    step("oret2",      0, 0, 1, 0, 0, 16'h0000, FAULT ? 16'h3001 : 16'h4001, 2, FAULT);
    step("oret3",      0, 0, 1, 0, 0, 16'h0000, FAULT ? 16'h2001 : 16'h3001, 1, FAULT);
    step("oret4",      0, 0, 1, 0, 0, 16'h0000, FAULT ? 16'h1001 : 16'h2001, 0, FAULT);
    step("uret",       0, 0, 1, 0, 0, 16'h0000, FAULT ? 16'h1001 : 16'h5001, 0, FAULT);
    // Reset in the middle of a call sequence.
    step("reset3",     1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    step("rcall1",     0, 1, 0, 0, 0, 16'h0A00, 16'h0A00, 1, 0);
    step("rcall2",     0, 1, 0, 0, 0, 16'h0B00, 16'h0B00, 2, 0);
    step("rcall3",     0, 1, 0, 0, 0, 16'h0C00, 16'h0C00, 3, 0);
    step("rstcall",    1, 1, 0, 0, 0, 16'h0D00, 16'h0000, 0, 0);
    // Slot 3 still holds 4001 from the overflow phase unless the reset-cycle call pushed.
    step("rstuf",      0, 0, 1, 0, 0, 16'h0000, FAULT ? 16'h0000 : 16'h4001, 0, FAULT);
    @(negedge clk);
    reset = 1'b0; call = 1'b0; ret = 1'b0; load = 1'b0; inc = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter for the Hack CPU core with an integrated hardware return-address stack. It keeps the classic reset / load / inc behaviour and adds `call` (push return address, jump) and `ret` (pop, jump) with configurable width and stack depth. It sits in the CPU datapath in place of the fixed 16-bit `pc` and drives the instruction-ROM address.

## Interface
Parameters:
- `WIDTH`, 16, PC and stack entry width in bits (≥2).
- `DEPTH`, 8, number of return-stack entries (power of two, ≥2).
- `RESET_VEC`, 0, value loaded into `out` on reset (WIDTH bits).

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  WIDTH  jump/call target.
- `load`  input  1  `out <= in`.
- `inc`  input  1  `out <= out + 1`.
- `call`  input  1  push `out + 1`, then `out <= in`.
- `ret`  input  1  `out <=` popped stack top.
- `out`  output  WIDTH  current PC (registered).
- `depth`  output  $clog2(DEPTH)+1  number of valid stack entries.
- `empty`  output  1  `depth == 0`.
- `full`  output  1  `depth == DEPTH`.
- `err`  output  1  sticky stack-fault flag (see Configuration).

## Operation
- Command priority per edge: `reset` > `call` > `ret` > `load` > `inc` > hold.
- `reset`: `out <= RESET_VEC`, `depth <= 0`, `err <= 0`; stack contents are don't-care.
- `call`: `stack[depth] <= out + 1`, `depth <= depth + 1`, `out <= in`.
- `ret`: `out <= stack[depth-1]`, `depth <= depth - 1`.
- `call` and `ret` together: `call` wins; `ret` is ignored.
- `load`/`inc` never touch the stack.
- Arithmetic is modulo 2^WIDTH: `out = all-ones` with `inc` gives 0; a call from all-ones pushes 0.
- `empty`/`full` are combinational decodes of the registered `depth`.

## Timing
- All outputs are registered state or decodes of it, so there is no combinational path from inputs to outputs.
- Every command takes effect at the rising edge where it is sampled. The new `out` and `depth` are visible after that edge (1-cycle latency).
- Back-to-back `call`/`ret` on consecutive cycles is legal at full rate.
- A `ret` in the cycle right after a `call` returns exactly `pre-call out + 1`.
- A `reset` asserted mid-sequence discards all stack state at that edge, and the `call`/`ret` sampled on that edge is ignored.
- Boundary conditions: overflow is `call` while `full`; underflow is `ret` while `empty`. The required behaviour depends on the macro below.

## Configuration
- Macro: `PC_STACK_FAULT_EN`.
- **Defined:**
  - Overflow: `out <= in`, the push is dropped, `depth` stays `DEPTH`, `err <= 1`.
  - Underflow: `out` holds, `depth` stays 0, `err <= 1`.
  - `err` stays set until `reset`.
- **Undefined:**
  - The stack is circular. Overflow overwrites the oldest entry (write index wraps mod DEPTH) and `depth` saturates at `DEPTH`.
  - Underflow jumps to the stale entry at the wrapped index and `depth` stays 0.
  - `err` is tied to 0.

## Test plan
- Reset/load/inc with WIDTH=16:
  - `reset=1` → `out=0000`, `empty=1`.
  - `load in=1234` → `out=1234`.
  - `inc` → `1235`.
  - Idle cycle → holds `1235`.
- Call/return nesting:
  - From `out=0010`: `call in=0100` → `out=0100`, `depth=1`.
  - `call in=0200` → `depth=2`.
  - `ret` → `out=0101`.
  - `ret` → `out=0011`, `empty=1`.
- Wrap-around: `load FFFF`, then `inc` → `0000`. `load FFFF`, then `call in=0050`, then `ret` → `out=0000`.
- Priority: `call=1`, `ret=1`, `load=1`, `in=0300` from `out=0020` → `out=0300`, `depth` increments, stacked value is `0021`.
- Overflow and underflow with DEPTH=4:
  - Five calls with the macro defined → `err=1`, `depth=4`, and four `ret` return the first four return addresses.
  - With the macro undefined → `err=0`, and the first `ret` returns the fifth return address.
  - `ret` while empty with the macro defined → `out` unchanged, `err=1`.
- Reset mid-operation: after 3 calls, assert `reset` together with `call` → `out=RESET_VEC`, `depth=0`, `err=0`, and nothing is pushed.
